// File: rtl/code_stream_decoder.sv
// code_stream_decoder: receives 3-bit codes over a valid/ready handshake and
// buffers them in a FIFO. Each code is replayed in arrival order as a
// fixed-width one-hot pulse, followed by an optional all-zero gap.
// Optional feature: define CODE_STREAM_DECODER_PARITY_EN to add in_par/par_err.
// Codes that arrive with bad odd parity are accepted but not stored.
module code_stream_decoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [2:0]               in_code,
`ifdef CODE_STREAM_DECODER_PARITY_EN
  input  logic                     in_par,
  output logic                     par_err,
`endif
  output logic                     in_ready,
  output logic [7:0]               out_onehot,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned MAXLEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int unsigned TW     = $clog2(MAXLEN) + 1;
  localparam bit          HAS_GAP = (GAP_LEN > 0);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] GAP_LOAD   = HAS_GAP ? TW'(GAP_LEN - 1) : '0;
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   tmr_q;
  logic [7:0]      onehot_q;
  logic [2:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            accept;
  logic            par_ok;
  logic            push;
  logic            pop;
  logic            not_empty;
  logic [2:0]      head;

`ifdef CODE_STREAM_DECODER_PARITY_EN
  logic par_err_q;

  assign par_ok  = ^{in_par, in_code};
  assign par_err = par_err_q;

  // Flag a rejected (bad parity) handshake for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= accept && !par_ok;
    end
  end
`else
  assign par_ok = 1'b1;
`endif

  assign in_ready  = rst_n && (count_q != FULL);
  assign accept    = in_valid && in_ready;
  assign push      = accept && par_ok;
  assign not_empty = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  assign out_onehot = onehot_q;
  assign busy       = (state_q != S_IDLE);
  assign count      = count_q;

  // Decide whether the FSM consumes the head entry on this edge
  always_comb begin
    pop = 1'b0;
    case (state_q)
      S_IDLE:  pop = not_empty;
      S_PULSE: pop = (tmr_q == '0) && !HAS_GAP && not_empty;
      S_GAP:   pop = (tmr_q == '0) && not_empty;
      default: pop = 1'b0;
    endcase
  end

  // Occupancy next-state: +1 push, -1 pop, unchanged for both or neither
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_code;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Pulse/gap sequencer with registered one-hot output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      onehot_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q  <= S_PULSE;
            onehot_q <= 8'h01 << head;
            tmr_q    <= PULSE_LOAD;
          end
        end
        S_PULSE: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - TW'(1);
          end else if (HAS_GAP) begin
            state_q  <= S_GAP;
            onehot_q <= '0;
            tmr_q    <= GAP_LOAD;
          end else if (pop) begin
            onehot_q <= 8'h01 << head;
            tmr_q    <= PULSE_LOAD;
          end else begin
            state_q  <= S_IDLE;
            onehot_q <= '0;
          end
        end
        S_GAP: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - TW'(1);
          end else if (pop) begin
            state_q  <= S_PULSE;
            onehot_q <= 8'h01 << head;
            tmr_q    <= PULSE_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          onehot_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_stream_decoder.sv
// Testbench for code_stream_decoder: scoreboard of accepted codes checked
// against the one-hot pulse stream, plus directed latency, backpressure,
// reset, back-to-back (GAP_LEN=0) and parity scenarios.
module tb_code_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = '0;
  logic       in_ready;
  logic [7:0] out_onehot;
  logic       busy;
  logic [2:0] count;

  logic       v2 = 1'b0;
  logic [2:0] code2 = '0;
  logic       ready2;
  logic [7:0] out2;
  logic       busy2;
  logic [2:0] count2;

`ifdef CODE_STREAM_DECODER_PARITY_EN
  logic in_par = 1'b0;
  logic par_err;
  logic par2;
  logic par_err2;
  assign par2 = ~^code2;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;

  logic [2:0]  exp_q[$];
  int unsigned run = 0;
  int unsigned gap_left = 0;
  logic [7:0]  cur = '0;
  bit          thr_en = 1'b0;
  bit          thr_prev = 1'b0;
  bit          have_start = 1'b0;
  int unsigned last_start = 0;
  bit          saw_full = 1'b0;

  code_stream_decoder #(.DEPTH(4), .PULSE_LEN(2), .GAP_LEN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
`ifdef CODE_STREAM_DECODER_PARITY_EN
    .in_par(in_par), .par_err(par_err),
`endif
    .in_ready(in_ready), .out_onehot(out_onehot), .busy(busy), .count(count)
  );

  code_stream_decoder #(.DEPTH(4), .PULSE_LEN(2), .GAP_LEN(0)) dut_b2b (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_code(code2),
`ifdef CODE_STREAM_DECODER_PARITY_EN
    .in_par(par2), .par_err(par_err2),
`endif
    .in_ready(ready2), .out_onehot(out2), .busy(busy2), .count(count2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard monitor: records accepted codes and checks the pulse stream
  always @(negedge clk) begin
    logic [2:0] c;
    bit         rec;
    if (!rst_n) begin
      exp_q.delete();
      run = 0;
      gap_left = 0;
      have_start = 1'b0;
    end else begin
      check("ready_rule", in_ready, (count != 3'd4));
      check("count_max", (count <= 3'd4), 1);
      if (count == 3'd4 && !in_ready) saw_full = 1'b1;
      if (thr_en && !thr_prev) have_start = 1'b0;
      thr_prev = thr_en;
      if (out_onehot != 8'h00) begin
        check("busy_in_pulse", busy, 1);
        if (run == 0) begin
          if (gap_left != 0) check("gap_short", gap_left, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", out_onehot, 0);
          end else begin
            c = exp_q.pop_front();
            cur = 8'h01 << c;
            check("pulse_code", out_onehot, cur);
            if (thr_en && have_start) check("throughput", cyc - last_start, 3);
            last_start = cyc;
            have_start = 1'b1;
          end
          run = 1;
        end else begin
          check("pulse_hold", out_onehot, cur);
          run++;
        end
        if (run == 2) begin
          run = 0;
          gap_left = 1;
        end
      end else begin
        if (run != 0) begin
          check("pulse_len", run, 2);
          run = 0;
        end
        if (gap_left != 0) gap_left--;
      end
      rec = in_valid && in_ready;
`ifdef CODE_STREAM_DECODER_PARITY_EN
      rec = rec && (^{in_par, in_code});
`endif
      if (rec) exp_q.push_back(in_code);
    end
  end

  // Present one code and hold it until accepted; returns at posedge+1
  task automatic send(input logic [2:0] c);
    int unsigned n;
    logic acc;
    in_code = c;
    in_valid = 1'b1;
`ifdef CODE_STREAM_DECODER_PARITY_EN
    in_par = ~^c;
`endif
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && count == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b2b_exp [5];
    bit found;

    // Reset state
    repeat (3) @(posedge clk);
    check("rst_ready_low", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out", out_onehot, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single code latency and pulse shape
    send(3'd5);
    in_valid = 1'b0;
    @(negedge clk);
    check("single_cnt_e1", count, 1);
    check("single_out_e1", out_onehot, 8'h00);
    @(negedge clk);
    check("single_out_e2", out_onehot, 8'h20);
    check("single_cnt_e2", count, 0);
    check("single_busy_e2", busy, 1);
    @(negedge clk);
    check("single_out_e3", out_onehot, 8'h20);
    @(negedge clk);
    check("single_out_e4", out_onehot, 8'h00);
    check("single_busy_e4", busy, 1);
    @(negedge clk);
    check("single_busy_e5", busy, 0);
    @(posedge clk);
    #1;
    drain();

    // All codes in order under backlog
    thr_en = 1'b1;
    for (int c = 0; c < 8; c++) send(3'(c));
    in_valid = 1'b0;
    drain();
    thr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: seven codes into a four-deep FIFO
    thr_en = 1'b1;
    saw_full = 1'b0;
    for (int c = 0; c < 7; c++) send(3'(c));
    in_valid = 1'b0;
    drain();
    thr_en = 1'b0;
    check("saw_full", saw_full, 1);

    // Asynchronous reset during the pulse of code 2 with three codes buffered
    for (int c = 1; c < 6; c++) send(3'(c));
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (out_onehot == 8'h04) found = 1'b1;
    end
    check("mid_found", found, 1);
    check("mid_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", out_onehot, 8'h00);
    check("mid_rst_count", count, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale", out_onehot, 8'h00);
    end
    @(posedge clk);
    #1;

`ifdef CODE_STREAM_DECODER_PARITY_EN
    // Bad parity: handshake completes, nothing stored
    in_code = 3'd4;
    in_par = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("par_err_set", par_err, 1);
    check("par_bad_count", count, 0);
    @(negedge clk);
    check("par_err_clear", par_err, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("par_no_pulse", out_onehot, 8'h00);
    end
    @(posedge clk);
    #1;
    send(3'd4);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("par_err_quiet", par_err, 0);
    end
    @(posedge clk);
    #1;
    drain();
`endif

    // Back-to-back pulses with no gap on the GAP_LEN=0 instance
    b2b_exp[0] = 8'h08;
    b2b_exp[1] = 8'h08;
    b2b_exp[2] = 8'h40;
    b2b_exp[3] = 8'h40;
    b2b_exp[4] = 8'h00;
    check("b2b_ready", ready2, 1);
    code2 = 3'd3;
    v2 = 1'b1;
    @(posedge clk);
    #1;
    code2 = 3'd6;
    @(negedge clk);
    check("b2b_out_e1", out2, 8'h00);
    @(posedge clk);
    #1;
    v2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("b2b_out", out2, b2b_exp[k]);
    end
    check("b2b_idle", busy2, 0);
    check("b2b_count", count2, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
